// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg
// Shared definitions for the single-port RAM controller slice:
//   state_e       controller state (INIT = zero-fill sweep, RUN = serving requests)
//   RD_LAT_MIN/MAX legal bounds of the read-latency parameter
//   be_width()    number of byte-enable bits for a given data width
package sp_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe
// Read-latency delay line for the RAM controller. A read result enters at
// in_valid and leaves on out_valid exactly RD_LAT cycles later.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_err      read accepted this cycle / read was out of range
//   in_data               data looked up at the accept edge
//   out_valid, out_err    one-cycle pulses at the end of the line
//   out_data              read data; holds its value between pulses
module ram_rd_pipe
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    // Latency forced into the supported range so a bad override still elaborates.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [LAT-1:0]    valid_q, valid_d;
    logic [LAT-1:0]    err_q, err_d;
    logic [LAT:0]      valid_chain;
    logic [LAT:0]      err_chain;
    logic [DATA_W-1:0] data_q     [LAT];
    logic [DATA_W-1:0] data_d     [LAT];
    logic [DATA_W-1:0] data_chain [LAT+1];

    // Each stage loads data only when a valid result moves into it, so the
    // last stage (and therefore out_data) holds between read pulses.
    always_comb begin
        valid_chain   = {valid_q, in_valid};
        err_chain     = {err_q, in_err};
        data_chain[0] = in_data;
        for (int i = 0; i < LAT; i++) begin
            data_chain[i+1] = data_q[i];
        end
        valid_d = valid_chain[LAT-1:0];
        err_d   = err_chain[LAT-1:0];
        for (int i = 0; i < LAT; i++) begin
            data_d[i] = valid_chain[i] ? data_chain[i] : data_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_err   = err_q[LAT-1];
    assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl
// Single-port RAM with byte enables, pipelined reads and an optional
// zero-fill sweep after reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid, ready    request handshake (accepted when both are high)
//   wr_rd           1 = write, 0 = read
//   addr, wdata, be word address, write data, per-byte write enables
//   rdata, rvalid   read data and its one-cycle qualifier (RD_LAT after accept)
//   err             one-cycle pulse for an access with addr >= DEPTH
//   busy            zero-fill sweep in progress
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid,
    output logic                        ready,
    input  logic                        wr_rd,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [be_width(DATA_W)-1:0] be,
    output logic [DATA_W-1:0]           rdata,
    output logic                        rvalid,
    output logic                        err,
    output logic                        busy
);

    localparam int     BE_W      = be_width(DATA_W);
    localparam state_e RST_STATE = (CLEAR_ON_RST != 0) ? ST_INIT : ST_RUN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_err_q, wr_err_d;
    logic              sweep_we;
    logic              accept;
    logic              in_range;
    logic              mem_we;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              pipe_valid;
    logic              pipe_err;
    logic [DATA_W-1:0] pipe_data;

    logic [DATA_W-1:0] mem [DEPTH];

    // The address is compared at full width so an out-of-range address never
    // aliases onto a real word, even when DEPTH is not a power of two.
    assign ready    = !rst && (state_q == ST_RUN);
    assign accept   = valid && ready;
    assign in_range = 32'(addr) < 32'(DEPTH);
    assign mem_we   = accept && wr_rd && in_range;
    assign rd_req   = accept && !wr_rd;
    assign rd_data  = in_range ? mem[addr] : '0;

    // Sweep walks cnt through 0..DEPTH-1, one zero write per cycle, and hands
    // over to RUN on the cycle after the final write.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        wr_err_d = accept && wr_rd && !in_range;
        if (state_q == ST_INIT) begin
            sweep_we = !rst;
            cnt_d    = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Storage array: sweep writes whole words, requests write selected bytes.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt_q] <= '0;
        end else if (mem_we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_req),
        .in_err    (rd_req && !in_range),
        .in_data   (rd_data),
        .out_valid (pipe_valid),
        .out_err   (pipe_err),
        .out_data  (pipe_data)
    );

    // Outputs are forced to their reset values for as long as rst is held.
    assign rvalid = !rst && pipe_valid;
    assign err    = !rst && (pipe_err || wr_err_q);
    assign rdata  = rst ? '0 : pipe_data;
    assign busy   = rst ? (CLEAR_ON_RST != 0) : (state_q == ST_INIT);

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// tb_sp_ram_ctrl
// Three controller instances with independent stimulus:
//   inst 0: DEPTH=256, RD_LAT=1
//   inst 1: DEPTH=256, RD_LAT=2
//   inst 2: DEPTH=200, RD_LAT=3
module tb_sp_ram_ctrl;

    localparam int N_INST = 3;

    logic                   clk;
    logic [N_INST-1:0]      rst, valid, wr_rd, ready, rvalid, err, busy;
    logic [N_INST-1:0][7:0] addr;
    logic [N_INST-1:0][31:0] wdata, rdata;
    logic [N_INST-1:0][3:0] be;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        int          inst;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    localparam int N_VEC = 20;
    vec_t vecs [N_VEC];

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        sp_ram_ctrl #(
            .DATA_W       (32),
            .DEPTH        ((g == 2) ? 200 : 256),
            .RD_LAT       (g + 1),
            .CLEAR_ON_RST (1)
        ) u_dut (
            .clk    (clk),
            .rst    (rst[g]),
            .valid  (valid[g]),
            .ready  (ready[g]),
            .wr_rd  (wr_rd[g]),
            .addr   (addr[g]),
            .wdata  (wdata[g]),
            .be     (be[g]),
            .rdata  (rdata[g]),
            .rvalid (rvalid[g]),
            .err    (err[g]),
            .busy   (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, required $finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Releases rst on one instance and measures how long busy stays high.
    task automatic releaseAndCount(input int i, input int exp_n, input string name);
        int n;
        bit bad;
        n   = 0;
        bad = 1'b0;
        rst[i] = 1'b0;
        while (busy[i] === 1'b1 && n < 1000) begin
            if (ready[i] !== 1'b0 || rvalid[i] !== 1'b0) bad = 1'b1;
            cycle();
            n++;
        end
        checkOutput({name, " sweep length"}, n, exp_n);
        checkOutput({name, " ready/rvalid low during sweep"}, {31'd0, bad}, 0);
        checkOutput({name, " ready after sweep"}, {31'd0, ready[i]}, 1);
        checkOutput({name, " busy after sweep"}, {31'd0, busy[i]}, 0);
    endtask

    // Back-to-back reads of addresses 0..n-1; mode 0 expects zeros, mode 1
    // expects each word to hold its own address.
    task automatic streamRead(input int i, input int n, input int mode);
        int lat;
        int k;
        bit exp_v;
        lat      = i + 1;
        valid[i] = 1'b1;
        wr_rd[i] = 1'b0;
        addr[i]  = 8'd0;
        for (int c = 0; c < n + lat + 1; c++) begin
            cycle();
            exp_v = (c >= lat - 1) && (c - (lat - 1) < n);
            k     = c - (lat - 1);
            checkOutput($sformatf("inst%0d stream rvalid c%0d", i, c), {31'd0, rvalid[i]}, {31'd0, exp_v});
            checkOutput($sformatf("inst%0d stream err c%0d", i, c), {31'd0, err[i]}, 0);
            if (exp_v) begin
                checkOutput($sformatf("inst%0d stream rdata k%0d", i, k), rdata[i],
                            (mode == 0) ? 32'd0 : 32'(k));
            end
            if (c + 1 < n) addr[i] = 8'(c + 1);
            else valid[i] = 1'b0;
        end
    endtask

    // One table transaction, followed by checks at the expected response cycle.
    task automatic applyStimulus(input int idx, input vec_t v);
        int i;
        int lat;
        i        = v.inst;
        lat      = i + 1;
        valid[i] = 1'b1;
        wr_rd[i] = v.wr;
        addr[i]  = v.addr;
        wdata[i] = v.wdata;
        be[i]    = v.be;
        cycle();
        valid[i] = 1'b0;
        wr_rd[i] = 1'b0;
        if (v.wr) begin
            checkOutput($sformatf("vec%0d write err", idx), {31'd0, err[i]}, {31'd0, v.exp_err});
            checkOutput($sformatf("vec%0d write rvalid", idx), {31'd0, rvalid[i]}, 0);
            checkOutput($sformatf("vec%0d rdata held", idx), rdata[i], v.exp_rdata);
        end else begin
            for (int c = 1; c < lat; c++) begin
                checkOutput($sformatf("vec%0d early rvalid", idx), {31'd0, rvalid[i]}, 0);
                cycle();
            end
            checkOutput($sformatf("vec%0d rvalid", idx), {31'd0, rvalid[i]}, 1);
            checkOutput($sformatf("vec%0d rdata", idx), rdata[i], v.exp_rdata);
            checkOutput($sformatf("vec%0d read err", idx), {31'd0, err[i]}, {31'd0, v.exp_err});
        end
        cycle();
        checkOutput($sformatf("vec%0d rvalid pulse end", idx), {31'd0, rvalid[i]}, 0);
        checkOutput($sformatf("vec%0d err pulse end", idx), {31'd0, err[i]}, 0);
    endtask

    initial begin
        //            inst wr    addr    wdata          be     exp_rdata      err
        vecs[0]  = '{0, 1'b1, 8'd5,   32'hAABBCCDD, 4'hF, 32'h00000007, 1'b0};
        vecs[1]  = '{0, 1'b1, 8'd5,   32'h11223344, 4'h5, 32'h00000007, 1'b0};
        vecs[2]  = '{0, 1'b0, 8'd5,   32'h0,        4'h0, 32'hAA22CC44, 1'b0};
        vecs[3]  = '{0, 1'b1, 8'd5,   32'hFFFFFFFF, 4'h0, 32'hAA22CC44, 1'b0};
        vecs[4]  = '{0, 1'b0, 8'd5,   32'h0,        4'h0, 32'hAA22CC44, 1'b0};
        vecs[5]  = '{0, 1'b1, 8'd9,   32'h12345678, 4'h8, 32'hAA22CC44, 1'b0};
        vecs[6]  = '{0, 1'b0, 8'd9,   32'h0,        4'h0, 32'h12000000, 1'b0};
        vecs[7]  = '{0, 1'b1, 8'd255, 32'hDEADBEEF, 4'hF, 32'h12000000, 1'b0};
        vecs[8]  = '{0, 1'b0, 8'd255, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{0, 1'b0, 8'd0,   32'h0,        4'h0, 32'h00000000, 1'b0};
        vecs[10] = '{2, 1'b1, 8'd250, 32'hFFFFFFFF, 4'hF, 32'h00000007, 1'b1};
        vecs[11] = '{2, 1'b0, 8'd50,  32'h0,        4'h0, 32'h00000000, 1'b0};
        vecs[12] = '{2, 1'b0, 8'd250, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[13] = '{2, 1'b1, 8'd199, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0};
        vecs[14] = '{2, 1'b0, 8'd199, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[15] = '{2, 1'b0, 8'd200, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[16] = '{1, 1'b1, 8'd7,   32'h000000AB, 4'h1, 32'h00000007, 1'b0};
        vecs[17] = '{1, 1'b0, 8'd7,   32'h0,        4'h0, 32'h000000AB, 1'b0};
        vecs[18] = '{1, 1'b1, 8'd3,   32'hAABBCCDD, 4'h6, 32'h000000AB, 1'b0};
        vecs[19] = '{1, 1'b0, 8'd3,   32'h0,        4'h0, 32'h00BBCC03, 1'b0};

        rst   = '1;
        valid = '0;
        wr_rd = '0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        cycle();
        cycle();

        // Outputs while reset is held.
        for (int i = 0; i < N_INST; i++) begin
            checkOutput($sformatf("inst%0d rst ready", i), {31'd0, ready[i]}, 0);
            checkOutput($sformatf("inst%0d rst rvalid", i), {31'd0, rvalid[i]}, 0);
            checkOutput($sformatf("inst%0d rst err", i), {31'd0, err[i]}, 0);
            checkOutput($sformatf("inst%0d rst rdata", i), rdata[i], 0);
            checkOutput($sformatf("inst%0d rst busy", i), {31'd0, busy[i]}, 1);
        end

        releaseAndCount(0, 256, "inst0");
        releaseAndCount(1, 256, "inst1");
        releaseAndCount(2, 200, "inst2");

        $display("[TB] zero-fill readback on inst0");
        streamRead(0, 256, 0);

        $display("[TB] latency sweep");
        for (int i = 0; i < N_INST; i++) begin
            valid[i] = 1'b1;
            wr_rd[i] = 1'b1;
            be[i]    = 4'hF;
            for (int a = 0; a < 8; a++) begin
                addr[i]  = 8'(a);
                wdata[i] = 32'(a);
                cycle();
            end
            valid[i] = 1'b0;
            wr_rd[i] = 1'b0;
            streamRead(i, 8, 1);
        end

        $display("[TB] directed vectors");
        for (int v = 0; v < N_VEC; v++) begin
            applyStimulus(v, vecs[v]);
        end

        $display("[TB] read right after write to the same address");
        for (int i = 0; i < N_INST; i += 2) begin
            valid[i] = 1'b1;
            wr_rd[i] = 1'b1;
            addr[i]  = 8'd20;
            wdata[i] = 32'h5A5A0000 + 32'(i);
            be[i]    = 4'hF;
            cycle();
            wr_rd[i] = 1'b0;
            cycle();
            valid[i] = 1'b0;
            for (int c = 1; c < i + 1; c++) cycle();
            checkOutput($sformatf("inst%0d raw rvalid", i), {31'd0, rvalid[i]}, 1);
            checkOutput($sformatf("inst%0d raw rdata", i), rdata[i], 32'h5A5A0000 + 32'(i));
            cycle();
        end

        $display("[TB] reset during the sweep on inst1");
        rst[1] = 1'b1;
        cycle();
        rst[1] = 1'b0;
        repeat (50) cycle();
        checkOutput("inst1 busy mid-sweep", {31'd0, busy[1]}, 1);
        rst[1] = 1'b1;
        cycle();
        checkOutput("inst1 busy in rst", {31'd0, busy[1]}, 1);
        releaseAndCount(1, 256, "inst1 restart");
        streamRead(1, 8, 0);

        $display("[TB] reset with a read in flight on inst2");
        valid[2] = 1'b1;
        wr_rd[2] = 1'b0;
        addr[2]  = 8'd5;
        cycle();
        valid[2] = 1'b0;
        rst[2]   = 1'b1;
        cycle();
        checkOutput("inst2 mid-read rvalid", {31'd0, rvalid[2]}, 0);
        checkOutput("inst2 mid-read busy", {31'd0, busy[2]}, 1);
        checkOutput("inst2 mid-read ready", {31'd0, ready[2]}, 0);
        releaseAndCount(2, 200, "inst2 mid-read");
        streamRead(2, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
